// File: rtl/ps2_host_tx_sequencer.sv
// ps2_host_tx_sequencer: host-to-device PS/2 command transmitter.
// Inhibits the PS/2 clock, issues request-to-send, shifts out
// {stop, odd parity, data} on device clock falling edges, checks the ACK
// and releases the bus.
// Optional feature macro: PS2_TX_RETRY_EN -- when defined, a NACK or timeout
// triggers up to MAX_RETRIES full re-sends before the failure is reported.
module ps2_host_tx_sequencer #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       rx_busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_RELEASE,
    ST_FAIL
  } state_t;

  state_t state;
  state_t state_next;

  logic          clk_s1;
  logic          clk_s2;
  logic          clk_prev;
  logic          data_s1;
  logic          data_s2;
  logic          lines_idle;
  logic          fe;
  logic [CW-1:0] cyc_cnt;
  logic [3:0]    edge_cnt;
  logic [9:0]    shift_reg;
  logic [7:0]    cmd_reg;
  logic          tx_bit;
  logic          accept;
  logic          inhibit_done;
  logic          timeout;
  logic          timed_now;
  logic          timed_next;
  logic          nack;
  logic          retry_ok;

  // A falling edge of the synchronised device clock advances the frame
  assign fe           = clk_prev & ~clk_s2;
  assign accept       = cmd_valid & cmd_ready;
  assign inhibit_done = (cyc_cnt == CW'(INHIBIT_CYCLES - 1));
  assign timeout      = (cyc_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timed_now    = state inside {ST_RTS, ST_SHIFT, ST_ACK, ST_RELEASE};
  assign timed_next   = state_next inside {ST_RTS, ST_SHIFT, ST_ACK, ST_RELEASE};
  assign nack         = (state == ST_ACK) & fe & data_s2;

  // Pad synchronisers; idle bus reads high so reset values avoid a false edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      clk_prev   <= 1'b1;
      data_s1    <= 1'b1;
      data_s2    <= 1'b1;
      lines_idle <= 1'b0;
    end else begin
      clk_s1     <= ps2_clk_in;
      clk_s2     <= clk_s1;
      clk_prev   <= clk_s2;
      data_s1    <= ps2_data_in;
      data_s2    <= data_s1;
      lines_idle <= clk_s2 & data_s2;
    end
  end

`ifdef PS2_TX_RETRY_EN
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  logic [RW-1:0] retry_cnt;

  // Count re-attempts of the current command; cleared on every accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retry_cnt <= '0;
    end else if (accept) begin
      retry_cnt <= '0;
    end else if (state == ST_FAIL && retry_ok) begin
      retry_cnt <= retry_cnt + RW'(1);
    end
  end

  assign retry_ok = (int'(retry_cnt) < MAX_RETRIES);
`else
  // Every failure is final; the comparison is constant false for any legal MAX_RETRIES
  assign retry_ok = (MAX_RETRIES < 0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; timeout only applies once the device owns the clock
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_INHIBIT;
      end
      ST_INHIBIT: begin
        if (inhibit_done) state_next = ST_RTS;
      end
      ST_RTS: begin
        if (fe)           state_next = ST_SHIFT;
        else if (timeout) state_next = ST_FAIL;
      end
      ST_SHIFT: begin
        if (fe && edge_cnt == 4'd9) state_next = ST_ACK;
        else if (timeout)           state_next = ST_FAIL;
      end
      ST_ACK: begin
        if (fe)           state_next = data_s2 ? ST_FAIL : ST_RELEASE;
        else if (timeout) state_next = ST_FAIL;
      end
      ST_RELEASE: begin
        if (lines_idle)   state_next = ST_IDLE;
        else if (timeout) state_next = ST_FAIL;
      end
      ST_FAIL: begin
        state_next = retry_ok ? ST_INHIBIT : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode; a shifted 1 releases the data line, FAIL releases both
  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx_done     = 1'b0;
    tx_err      = 1'b0;
    busy        = (state != ST_IDLE);
    cmd_ready   = (state == ST_IDLE) & ~rx_busy;
    case (state)
      ST_INHIBIT: ps2_clk_oe  = 1'b1;
      ST_RTS:     ps2_data_oe = 1'b1;
      ST_SHIFT:   ps2_data_oe = ~tx_bit;
      ST_RELEASE: tx_done     = lines_idle;
      ST_FAIL:    tx_err      = ~retry_ok;
      default:    ;
    endcase
  end

  // Datapath: phase counter, frame shifter, edge counter and error code
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt   <= '0;
      edge_cnt  <= '0;
      shift_reg <= '1;
      cmd_reg   <= '0;
      tx_bit    <= 1'b1;
      err_code  <= 2'b00;
    end else begin
      // Inhibit and the RTS..RELEASE window are timed separately
      if ((state == ST_INHIBIT && state_next == ST_INHIBIT) || (timed_now && timed_next)) begin
        cyc_cnt <= cyc_cnt + CW'(1);
      end else begin
        cyc_cnt <= '0;
      end

      if (accept) begin
        cmd_reg  <= cmd_data;
        err_code <= 2'b00;
      end

      // The frame is rebuilt from the latched byte on every attempt
      if (state == ST_INHIBIT) begin
        shift_reg <= {1'b1, ~^cmd_reg, cmd_reg};
        edge_cnt  <= '0;
        tx_bit    <= 1'b1;
      end else if (fe && (state == ST_RTS || state == ST_SHIFT)) begin
        tx_bit    <= shift_reg[0];
        shift_reg <= {1'b1, shift_reg[9:1]};
        edge_cnt  <= edge_cnt + 4'd1;
      end else if (fe && state == ST_ACK) begin
        edge_cnt  <= edge_cnt + 4'd1;
      end

      if (state_next == ST_FAIL && state != ST_FAIL) begin
        err_code <= nack ? 2'b01 : 2'b10;
      end
    end
  end

endmodule

// File: doc/ps2_host_tx_sequencer.md
# ps2_host_tx_sequencer

Host-to-device command sequencer for the PS/2 port. It takes one command byte (for example 0xFF reset, 0xED set-LEDs, 0xF4 enable) and takes ownership of the open-drain PS/2 lines to send it: it inhibits the clock, issues the request-to-send, and shifts out data, parity and stop on device-generated clock edges. It then checks the device ACK and releases the bus. It sits beside the PS/2 receive path, and the receiver's busy flag arbitrates bus ownership.

## Interface
- INHIBIT_CYCLES, 5000, number of clk cycles the host holds PS/2 clock low before request-to-send (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000, maximum clk cycles from request-to-send to ACK (15 ms at 50 MHz).
- MAX_RETRIES, 2, number of re-attempts after a NACK or timeout (used only with PS2_TX_RETRY_EN).
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-low reset.
- cmd_data  in  8  command byte, sampled when cmd_valid && cmd_ready.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when state is IDLE and rx_busy=0.
- rx_busy  in  1  receiver mid-frame; no new transaction starts while it is high.
- ps2_clk_in  in  1  raw PS/2 clock pad level.
- ps2_data_in  in  1  raw PS/2 data pad level.
- ps2_clk_oe  out  1  1 pulls PS/2 clock low; 0 releases it.
- ps2_data_oe  out  1  1 pulls PS/2 data low; 0 releases it.
- busy  out  1  high whenever state is not IDLE.
- tx_done  out  1  one-cycle pulse when the device ACK is received and the bus is released.
- tx_err  out  1  one-cycle pulse on final failure.
- err_code  out  2  holds its value until the next accept. 01 = NACK, 10 = timeout.

## Operation
- Both pads pass through 2-flop synchronisers. A falling edge (fe) is detected on the synchronised clock: previous=1, current=0.
- The shift register holds {stop=1, parity, data[7:0]} and shifts out LSB first. Parity is odd: parity = ~^cmd_data.
- An edge counter runs 0..11 (4 bits). A cycle counter is wide enough for max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

States:
- IDLE
  - clk_oe=0, data_oe=0.
  - On accept, latch the byte, clear err_code and the retry count, then go to INHIBIT.
- INHIBIT
  - clk_oe=1.
  - After INHIBIT_CYCLES cycles: data_oe=1, then go to RTS. Data is asserted while clock is still low.
- RTS
  - clk_oe=0, data_oe=1. The timeout counter starts.
  - On the first fe, drive bit0, then go to SHIFT.
- SHIFT
  - Each fe drives the next bit: fe2..fe8 drive bit1..bit7, fe9 drives parity, fe10 drives stop.
  - The line is driven as data_oe = ~bit, so a 1 releases the line.
  - After fe10, go to ACK.
- ACK
  - On fe11, sample synchronised data.
  - Data 0 goes to RELEASE. Data 1 is a NACK and goes to FAIL.
- RELEASE
  - Wait for both synchronised lines to read 1.
  - Then pulse tx_done and go to IDLE.
- FAIL
  - With retry enabled and retries < MAX_RETRIES: increment retries, go to INHIBIT.
  - Otherwise: set err_code, pulse tx_err, go to IDLE.

Other rules:
- Timeout applies in RTS, SHIFT, ACK and RELEASE. When the count reaches TIMEOUT_CYCLES, err_code=10 and the state goes to FAIL. Lines are released in FAIL.
- A retry re-sends the same latched byte.
- cmd_valid while busy is ignored. The requester holds cmd_valid until cmd_ready.
- rx_busy rising after the accept has no effect, because the host owns the bus from INHIBIT onward.

## Timing
- Reset values: state=IDLE, clk_oe=0, data_oe=0, busy=0, tx_done=0, tx_err=0, err_code=00, counters 0.
- cmd_ready=1 after reset whenever rx_busy=0.
- On an accept at cycle N, ps2_clk_oe=1 from cycle N+1. data_oe=1 at N+1+INHIBIT_CYCLES, and clk_oe=0 in the same cycle.
- fe is detected 3 clk cycles after the pad falls. The next bit is driven on the cycle after fe detection, well within the device's low phase.
- tx_done follows the cycle in which both synchronised lines read high, plus one cycle.
- Reset asserted mid-transaction releases both lines immediately (asynchronously), with no pulse on tx_done or tx_err.

## Configuration
- PS2_TX_RETRY_EN
  - Defined: a NACK or timeout triggers up to MAX_RETRIES full re-sends (INHIBIT onward) before tx_err.
  - Undefined: the first NACK or timeout goes directly to tx_err. MAX_RETRIES is ignored and the retry counter is not built.

## Test plan
- Send 0xED with a device model clocking at 12 kHz and ACKing.
  - Sampled bits are 1,0,1,1,0,1,1,1, parity=1, stop=1.
  - Exactly one tx_done, and busy falls on the following cycle.
- Send 0xF4: parity bit=0 and ACK → tx_done. Send 0xFF: parity bit=1 and ACK → tx_done.
- Inhibit check: with INHIBIT_CYCLES=5000, ps2_clk_oe stays high for exactly 5000 cycles, and data_oe rises in the cycle clk_oe falls.
- Model NACKs (data high at clock 11), with retry enabled and MAX_RETRIES=2: three full INHIBIT sequences, then tx_err=1 and err_code=01. With the macro undefined: one attempt, then tx_err.
- Device never clocks, TIMEOUT_CYCLES=1000: tx_err with err_code=10, 1000 cycles after RTS, and both oe outputs are 0.
- Interlocks:
  - rx_busy=1 with cmd_valid=1: cmd_ready=0 and no oe activity. When rx_busy falls, the accept happens the next cycle.
  - Reset asserted during SHIFT: both oe outputs are 0 immediately, with no pulse on tx_done or tx_err.
